// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI transaction scheduler.
// State codes match the HEX4 debug display.
package spi_pkg;

  localparam int NUM_CS = 4;
  localparam int WORD_W = 32;
  localparam int SIZE_W = 5;
  localparam int MODE_W = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'hA,
    SETUP = 4'hB,
    XFER  = 4'hC,
    HOLD  = 4'hD,
    GAP   = 4'hE
  } state_t;

  typedef logic [1:0] cs_idx_t;

  function automatic logic [NUM_CS-1:0] cs_onehot(input cs_idx_t idx);
    logic [NUM_CS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick. Search starts one above the last winner and wraps;
// the pointer only moves when the caller accepts the pick.
module rr_arbiter4
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CS-1:0] req,
  input  logic              update,
  output cs_idx_t           winner,
  output logic              valid
);

  cs_idx_t ptr;
  cs_idx_t cand;

  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    cand   = ptr;
    // k = 4 wraps back to ptr itself, so the last winner has lowest priority
    for (int k = 1; k <= NUM_CS; k++) begin
      cand = ptr + 2'(k);
      if (!valid && req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 2'd3;
    end else if (update && valid) begin
      ptr <= winner;
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler of four chip-select requesters onto one SPI serializer,
// sequencing cs setup, transfer, cs hold and a minimum deselect gap.
//
// state | meaning
// IDLE  | arbitrate pending requests when enabled
// SETUP | cs_n low, counting setup time before sh_start
// XFER  | serializer running, waiting for sh_done
// HOLD  | cs_n still low, counting hold time
// GAP   | all cs_n high, counting minimum deselect time
module spi_xfer_scheduler
  import spi_pkg::*;
#(
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CS-1:0]        req,
  input  logic [NUM_CS*WORD_W-1:0] req_word,
  input  logic [NUM_CS*SIZE_W-1:0] req_size,
  input  logic [NUM_CS*MODE_W-1:0] req_mode,
  output logic [NUM_CS-1:0]        grant,
  output logic [NUM_CS-1:0]        done,
  output logic [WORD_W-1:0]        rx_word,
  output logic                     sh_start,
  output logic [WORD_W-1:0]        sh_word,
  output logic [SIZE_W-1:0]        sh_size,
  output logic [MODE_W-1:0]        sh_mode,
  input  logic                     sh_done,
  input  logic [WORD_W-1:0]        sh_rx_word,
  output logic [NUM_CS-1:0]        cs_n,
  output logic                     busy,
  output logic [1:0]               owner
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CS_GAP - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_CS-1:0]  cs_n_nxt, grant_nxt, done_nxt;
  logic [WORD_W-1:0]  rx_word_nxt, sh_word_nxt;
  logic [SIZE_W-1:0]  sh_size_nxt;
  logic [MODE_W-1:0]  sh_mode_nxt;
  logic               sh_start_nxt;
  cs_idx_t            owner_nxt;
  cs_idx_t            arb_winner;
  logic               arb_valid;
  logic               take;

  rr_arbiter4 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (take),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cs_n_nxt     = cs_n;
    grant_nxt    = '0;
    done_nxt     = '0;
    rx_word_nxt  = rx_word;
    sh_start_nxt = 1'b0;
    sh_word_nxt  = sh_word;
    sh_size_nxt  = sh_size;
    sh_mode_nxt  = sh_mode;
    owner_nxt    = owner;
    take         = 1'b0;

    case (state)
      IDLE: begin
        if (enable && arb_valid) begin
          take        = 1'b1;
          grant_nxt   = cs_onehot(arb_winner);
          owner_nxt   = arb_winner;
          sh_word_nxt = req_word[int'(arb_winner)*WORD_W +: WORD_W];
          sh_size_nxt = req_size[int'(arb_winner)*SIZE_W +: SIZE_W];
          sh_mode_nxt = req_mode[int'(arb_winner)*MODE_W +: MODE_W];
          cs_n_nxt    = ~cs_onehot(arb_winner);
          cnt_nxt     = SETUP_LOAD;
          state_nxt   = SETUP;
        end
      end

      SETUP: begin
        if (cnt == '0) begin
          sh_start_nxt = 1'b1;
          state_nxt    = XFER;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      XFER: begin
        if (sh_done) begin
          rx_word_nxt = sh_rx_word;
          done_nxt    = cs_onehot(owner);
          cnt_nxt     = HOLD_LOAD;
          state_nxt   = HOLD;
        end
      end

      HOLD: begin
        if (cnt == '0) begin
          cs_n_nxt  = '1;
          cnt_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      default: begin
        cs_n_nxt  = '1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cs_n     <= '1;
      grant    <= '0;
      done     <= '0;
      rx_word  <= '0;
      sh_start <= 1'b0;
      sh_word  <= '0;
      sh_size  <= '0;
      sh_mode  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cs_n     <= cs_n_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      rx_word  <= rx_word_nxt;
      sh_start <= sh_start_nxt;
      sh_word  <= sh_word_nxt;
      sh_size  <= sh_size_nxt;
      sh_mode  <= sh_mode_nxt;
      owner    <= owner_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule
